// File: rtl/sample_mul_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_mul_share_arbiter_if
// Purpose  : Requester-side operand/result handshake bundle for the shared
//            multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sample_mul_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 14
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ*DATA_W-1:0] rsp_data;
  logic [N_REQ-1:0]        rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/sample_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sample_mul_share_arbiter
// Purpose  : Round-robin time-sharing of one 2-stage signed multiplier among
//            N_REQ requesters, each with a private result register.
// Revision : 1.0 - initial release
// ============================================================================
module sample_mul_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  sample_mul_share_arbiter_if.slave bus,
  output logic                     busy
);
  localparam int                 c_TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [c_TAG_W-1:0] c_LAST  = c_TAG_W'(N_REQ - 1);

  logic [DATA_W-1:0]       r_a;
  logic [DATA_W-1:0]       r_b;
  logic [DATA_W-1:0]       r_p;
  logic [c_TAG_W-1:0]      r_tag1;
  logic [c_TAG_W-1:0]      r_tag2;
  logic [c_TAG_W-1:0]      r_rr_ptr;
  logic                    r_v1;
  logic                    r_v2;
  logic                    r_busy;
  logic [N_REQ-1:0]        r_rsp_valid;
  logic [N_REQ*DATA_W-1:0] r_rsp_data;

  logic [N_REQ-1:0]        w_inflight;
  logic [N_REQ-1:0]        w_eligible;
  logic [N_REQ-1:0]        w_grant;
  logic [N_REQ-1:0]        w_rsp_valid_nxt;
  logic [c_TAG_W-1:0]      w_gidx;
  logic [c_TAG_W-1:0]      w_ptr_nxt;
  logic [DATA_W-1:0]       w_sel_a;
  logic [DATA_W-1:0]       w_sel_b;
  logic [DATA_W-1:0]       w_prod;
  logic                    w_accept;

  // Per-slot state: IDLE -> S1 -> S2 (inflight) -> FULL (rsp_valid) -> IDLE.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    localparam logic [c_TAG_W-1:0] c_ID = c_TAG_W'(gi);

    assign w_inflight[gi] = (r_v1 && (r_tag1 == c_ID)) || (r_v2 && (r_tag2 == c_ID));
    assign w_eligible[gi] = bus.req_valid[gi] && !w_inflight[gi] && !r_rsp_valid[gi];
    assign w_rsp_valid_nxt[gi] = (r_v2 && (r_tag2 == c_ID))            ? 1'b1 :
                                 (r_rsp_valid[gi] && bus.rsp_ready[gi]) ? 1'b0 :
                                 r_rsp_valid[gi];
  end

  always_comb begin
    int   w_idx;
    logic w_found;
    w_grant = '0;
    w_gidx  = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && w_eligible[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gidx         = c_TAG_W'(w_idx);
        w_sel_a        = bus.req_a[w_idx*DATA_W +: DATA_W];
        w_sel_b        = bus.req_b[w_idx*DATA_W +: DATA_W];
      end
    end
    if (!ce || reset) w_grant = '0;
  end

  assign w_accept  = |w_grant;
  assign w_ptr_nxt = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

  // Low DATA_W bits of a product do not depend on operand signedness.
  assign w_prod = r_a * r_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else if (ce) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_tag1   <= w_gidx;
        r_rr_ptr <= w_ptr_nxt;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p    <= w_prod;
        r_tag2 <= r_tag1;
      end
      r_rsp_valid <= w_rsp_valid_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        if (r_v2 && (r_tag2 == c_TAG_W'(i))) r_rsp_data[i*DATA_W +: DATA_W] <= r_p;
      end
      r_busy <= w_accept | r_v1 | (|w_rsp_valid_nxt);
    end
  end

  // A load must only ever target an empty slot, so it can never race a consume.
  a_load_into_free_slot: assert property (@(posedge clk) disable iff (reset)
    (ce && r_v2) |-> !r_rsp_valid[r_tag2]);

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sample_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_mul_share_arbiter
// Purpose  : Directed bench with result scoreboard for the shared multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_mul_share_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 14;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic busy;

  sample_mul_share_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  sample_mul_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] prod;
  } exp_t;

  int               n_vec = 0;
  int               n_err = 0;
  exp_t             sb[$];
  int               acc_log[$];
  logic [N_REQ-1:0] prev_rsp = '0;
  int               last_acc = 0;
  bit               last_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] mulw(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    return p[DATA_W-1:0];
  endfunction

  function automatic logic [31:0] rd(input int i);
    return 32'(bus.rsp_data[i*DATA_W +: DATA_W]);
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*DATA_W +: DATA_W] = DATA_W'(a);
    bus.req_b[i*DATA_W +: DATA_W] = DATA_W'(b);
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic ng();
    @(negedge clk);
  endtask

  // Inputs only change just after posedge, so a handshake seen here is the
  // one the next edge accepts; result arrivals are checked first.
  always @(negedge clk) begin : mon
    exp_t             e;
    logic [N_REQ-1:0] hs;
    chk("grant_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.rsp_valid[i] === 1'b1 && prev_rsp[i] !== 1'b1) begin
        chk("sb_underflow", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_slot", 32'(i), 32'(e.idx));
          chk("sb_data", rd(i), 32'(e.prod));
        end
      end
    end
    prev_rsp = bus.rsp_valid;
    hs = (ce && !reset) ? (bus.req_valid & bus.req_ready) : '0;
    if (reset) begin
      sb.delete();
      last_vld = 1'b0;
    end else if (ce) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i]) begin
          e.idx  = i;
          e.prod = mulw(bus.req_a[i*DATA_W +: DATA_W], bus.req_b[i*DATA_W +: DATA_W]);
          sb.push_back(e);
          acc_log.push_back(i);
          if (last_vld) chk("no_b2b", 32'(last_acc == i), 32'd0);
          last_acc = i;
        end
      end
      last_vld = |hs;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt1;
    reset         = 1'b1;
    ce            = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    // Reset state, with requests already pending.
    repeat (2) @(posedge clk);
    ng();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data != '0), 32'd0);
    tk();
    reset = 1'b0;
    bus.req_valid = '0;

    // Single op and latency.
    tk();
    set_op(0, 100, 200);
    bus.req_valid = 4'b0001;
    ng(); chk("t1_grant", 32'(bus.req_ready), 32'h1);
    tk(); bus.req_valid = '0;
    ng(); chk("t1_lat1", 32'(bus.rsp_valid), 32'h0); chk("t1_busy1", 32'(busy), 32'd1);
    ng(); chk("t1_lat2", 32'(bus.rsp_valid), 32'h0);
    ng(); chk("t1_rsp", 32'(bus.rsp_valid), 32'h1); chk("t1_data", rd(0), 32'd3616);
    repeat (3) ng();
    chk("t1_hold", 32'(bus.rsp_valid), 32'h1); chk("t1_busy_hold", 32'(busy), 32'd1);
    tk(); bus.rsp_ready = 4'b0001;
    ng(); chk("t1_pre_consume", 32'(bus.rsp_valid), 32'h1);
    tk(); bus.rsp_ready = '0;
    ng();
    chk("t1_consumed", 32'(bus.rsp_valid), 32'h0);
    chk("t1_busy_clr", 32'(busy), 32'd0);
    chk("t1_data_kept", rd(0), 32'd3616);

    // Signs and wrap.
    tk();
    set_op(0, -3, 5);
    set_op(1, 127, 129);
    set_op(2, -8192, -1);
    bus.req_valid = 4'b0111;
    repeat (7) ng();
    chk("t2_valid", 32'(bus.rsp_valid), 32'h7);
    chk("t2_full_no_grant", 32'(bus.req_ready), 32'h0);
    chk("t2_neg", rd(0), 32'h3FF1);
    chk("t2_wrap", rd(1), 32'h3FFF);
    chk("t2_min", rd(2), 32'h2000);
    tk(); bus.req_valid = '0; bus.rsp_ready = 4'b0111;
    tk(); bus.rsp_ready = '0;
    ng(); chk("t2_consumed", 32'(bus.rsp_valid), 32'h0);

    // Round robin at full throughput.
    tk();
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    acc_log.delete();
    for (int i = 0; i < N_REQ; i++) set_op(i, int'($urandom), int'($urandom));
    for (int c = 0; c < 20; c++) begin
      tk();
      for (int i = 0; i < N_REQ; i++) set_op(i, int'($urandom), int'($urandom));
    end
    bus.req_valid = '0;
    chk("rr_count", 32'(acc_log.size()), 32'd20);
    for (int k = 1; k < acc_log.size(); k++)
      chk("rr_order", 32'(acc_log[k]), 32'((acc_log[k-1] + 1) % N_REQ));
    repeat (6) tk();

    // Backpressure on requester 1.
    bus.rsp_ready = 4'b1101;
    acc_log.delete();
    bus.req_valid = '1;
    repeat (16) tk();
    cnt1 = 0;
    foreach (acc_log[k]) if (acc_log[k] == 1) cnt1++;
    chk("bp_one_grant", 32'(cnt1), 32'd1);
    chk("bp_others_run", 32'(acc_log.size() > 8), 32'd1);
    chk("bp_slot_full", 32'(bus.rsp_valid[1]), 32'd1);
    bus.req_valid = 4'b0010;
    ng(); chk("bp_blocked", 32'(bus.req_ready), 32'h0);
    tk(); bus.rsp_ready = '1;
    ng(); chk("bp_pre_consume", 32'(bus.req_ready), 32'h0);
    tk();
    ng(); chk("bp_regrant", 32'(bus.req_ready), 32'h2);
    tk(); bus.req_valid = '0;
    repeat (6) tk();

    // Clock-enable stall with an op in S1.
    bus.rsp_ready = 4'b1011;
    set_op(2, 300, -7);
    bus.req_valid = 4'b0100;
    ng(); chk("ce_grant", 32'(bus.req_ready), 32'h4);
    tk();
    ce = 1'b0;
    bus.req_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      ng();
      chk("ce_no_grant", 32'(bus.req_ready), 32'h0);
      chk("ce_rsp_frozen", 32'(bus.rsp_valid), 32'h0);
      chk("ce_busy_frozen", 32'(busy), 32'd1);
      tk();
    end
    ce = 1'b1;
    bus.req_valid = '0;
    ng(); chk("ce_s1", 32'(bus.rsp_valid), 32'h0);
    ng(); chk("ce_s2", 32'(bus.rsp_valid), 32'h0);
    ng(); chk("ce_rsp", 32'(bus.rsp_valid), 32'h4); chk("ce_data", rd(2), 32'h37CC);
    tk(); bus.rsp_ready = '1;
    tk();
    ng(); chk("ce_consumed", 32'(bus.rsp_valid), 32'h0);

    // Reset with ops in S1, S2 and one full slot.
    tk();
    bus.rsp_ready = '0;
    set_op(0, 11, 12);
    set_op(1, 13, 14);
    set_op(2, 15, 16);
    bus.req_valid = 4'b0111;
    repeat (3) tk();
    reset = 1'b1;
    bus.req_valid = '0;
    ng();
    chk("mr_one_full", 32'($countones(bus.rsp_valid)), 32'd1);
    chk("mr_busy", 32'(busy), 32'd1);
    tk();
    reset = 1'b0;
    ng();
    chk("mr_req_ready", 32'(bus.req_ready), 32'h0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mr_busy_clr", 32'(busy), 32'd0);
    chk("mr_rsp_data", 32'(bus.rsp_data != '0), 32'd0);
    for (int k = 0; k < 6; k++) begin
      ng(); chk("mr_discarded", 32'(bus.rsp_valid), 32'h0);
    end
    tk();
    for (int i = 0; i < N_REQ; i++) set_op(i, i + 2, -(i + 5));
    bus.req_valid = '1;
    ng(); chk("mr_first_grant", 32'(bus.req_ready), 32'h1);
    tk();
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (6) ng();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
